// File: rtl/wb_regbank_pkg.sv
// Shared constants, FSM state encoding and address helper for the Wishbone register bank.
package wb_regbank_pkg;

  localparam int unsigned DefDw         = 32;
  localparam int unsigned DefAw         = 32;
  localparam int unsigned DefNumRw      = 16;
  localparam int unsigned DefNumRo      = 4;
  localparam int unsigned DefWaitStates = 0;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StWait = 2'd1;
  localparam state_t StResp = 2'd2;

  // Number of low address bits that select a byte within one data word.
  function automatic int unsigned byte_off_bits(input int unsigned dw);
    return (dw > 8) ? $clog2(dw / 8) : 0;
  endfunction

endpackage

// File: rtl/wb_regbank_decode.sv
// Combinational byte-address to register-index decode and region classification.
module wb_regbank_decode
  import wb_regbank_pkg::*;
#(
  parameter int unsigned   DW        = DefDw,
  parameter int unsigned   AW        = DefAw,
  parameter int unsigned   NUM_RW    = DefNumRw,
  parameter int unsigned   NUM_RO    = DefNumRo,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   IW        = 4,
  parameter int unsigned   RIW       = 2
) (
  input  logic [AW-1:0]  adr_i,
  output logic           is_rw_o,
  output logic           is_ro_o,
  output logic [IW-1:0]  rw_idx_o,
  output logic [RIW-1:0] ro_idx_o
);

  localparam int unsigned Ob = byte_off_bits(DW);

  logic [AW-1:0] off;
  logic [AW-1:0] idx;
  logic          below;

  always_comb begin
    below    = (adr_i < BASE_ADDR);
    off      = adr_i - BASE_ADDR;
    idx      = off >> Ob;
    is_rw_o  = !below && (idx < AW'(NUM_RW));
    is_ro_o  = !below && (idx >= AW'(NUM_RW)) && (idx < AW'(NUM_RW + NUM_RO));
    rw_idx_o = IW'(idx);
    ro_idx_o = RIW'(idx - AW'(NUM_RW));
  end

endmodule

// File: rtl/wb_regbank_slave.sv
// Wishbone slave exposing RW control registers and RO status words with optional wait states.
module wb_regbank_slave
  import wb_regbank_pkg::*;
#(
  parameter int unsigned   DW          = DefDw,
  parameter int unsigned   AW          = DefAw,
  parameter int unsigned   NUM_RW      = DefNumRw,
  parameter int unsigned   NUM_RO      = DefNumRo,
  parameter int unsigned   WAIT_STATES = DefWaitStates,
  parameter logic [AW-1:0] BASE_ADDR   = '0
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic                                  wbs_cyc_i,
  input  logic                                  wbs_stb_i,
  input  logic                                  wbs_we_i,
  input  logic [DW/8-1:0]                       wbs_sel_i,
  input  logic [AW-1:0]                         wbs_adr_i,
  input  logic [DW-1:0]                         wbs_dat_i,
  output logic                                  wbs_ack_o,
  output logic                                  wbs_err_o,
  output logic [DW-1:0]                         wbs_dat_o,
  output logic                                  wbs_rdy_o,
  output logic [NUM_RW*DW-1:0]                  regs_o,
  output logic [NUM_RW-1:0]                     wr_pulse_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DW-1:0] status_i
);

  localparam int unsigned NB     = DW / 8;
  localparam int unsigned IW     = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;
  localparam int unsigned RIW    = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam logic [3:0]  WsLast = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic            we_q, we_d;
  logic [NB-1:0]   sel_q, sel_d;
  logic [DW-1:0]   wdat_q, wdat_d;
  logic [DW-1:0]   regs_q [NUM_RW];
  logic [DW-1:0]   regs_d [NUM_RW];
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic [NUM_RW-1:0] pulse_q, pulse_d;

  logic            req;
  logic            go_resp;
  logic [AW-1:0]   cur_adr;
  logic            cur_we;
  logic [NB-1:0]   cur_sel;
  logic [DW-1:0]   cur_dat;
  logic            is_rw;
  logic            is_ro;
  logic [IW-1:0]   rw_idx;
  logic [RIW-1:0]  ro_idx;
  logic [DW-1:0]   merged;

  assign req = wbs_cyc_i & wbs_stb_i;

  // In IDLE the live bus is decoded so a zero-wait response costs no extra cycle.
  always_comb begin
    if (state_q == StIdle) begin
      cur_adr = wbs_adr_i;
      cur_we  = wbs_we_i;
      cur_sel = wbs_sel_i;
      cur_dat = wbs_dat_i;
    end else begin
      cur_adr = adr_q;
      cur_we  = we_q;
      cur_sel = sel_q;
      cur_dat = wdat_q;
    end
  end

  wb_regbank_decode #(
    .DW        (DW),
    .AW        (AW),
    .NUM_RW    (NUM_RW),
    .NUM_RO    (NUM_RO),
    .BASE_ADDR (BASE_ADDR),
    .IW        (IW),
    .RIW       (RIW)
  ) u_decode (
    .adr_i    (cur_adr),
    .is_rw_o  (is_rw),
    .is_ro_o  (is_ro),
    .rw_idx_o (rw_idx),
    .ro_idx_o (ro_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          adr_d  = wbs_adr_i;
          we_d   = wbs_we_i;
          sel_d  = wbs_sel_i;
          wdat_d = wbs_dat_i;
          cnt_d  = '0;
          if (WAIT_STATES == 0) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == WsLast) begin
          state_d = StResp;
          go_resp = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    merged = regs_q[rw_idx];
    for (int b = 0; b < NB; b++) begin
      if (cur_sel[b]) merged[b*8 +: 8] = cur_dat[b*8 +: 8];
    end
  end

  // Writes, read data and the response strobe all resolve on the edge entering RESP.
  always_comb begin
    regs_d  = regs_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    pulse_d = '0;
    rdat_d  = rdat_q;
    if (go_resp) begin
      if (is_rw) begin
        ack_d = 1'b1;
        if (cur_we) begin
          regs_d[rw_idx]  = merged;
          pulse_d[rw_idx] = 1'b1;
        end else begin
          rdat_d = regs_q[rw_idx];
        end
      end else if (is_ro && !cur_we) begin
        ack_d  = 1'b1;
        rdat_d = status_i[ro_idx*DW +: DW];
      end else begin
        err_d = 1'b1;
        if (!cur_we) rdat_d = '0;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
      pulse_q <= '0;
      for (int k = 0; k < NUM_RW; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
      pulse_q <= pulse_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar k = 0; k < NUM_RW; k++) begin : g_regs_out
    assign regs_o[k*DW +: DW] = regs_q[k];
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_err_o  = err_q;
  assign wbs_dat_o  = rdat_q;
  assign wbs_rdy_o  = (state_q == StIdle);
  assign wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_wb_regbank_slave.sv
// Randomized self-checking bench: zero-wait and three-wait instances against a register model.
module tb_wb_regbank_slave;

  localparam int          DW   = 32;
  localparam int          AW   = 16;
  localparam int          NRW  = 8;
  localparam int          NRO  = 4;
  localparam logic [15:0] BASE = 16'h0100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]        sel = '0;
  logic [15:0]       adr = '0;
  logic [31:0]       wdat = '0;
  logic [NRO*32-1:0] status = '0;
  int                dsel = 0;

  logic cyc0, stb0, cyc3, stb3;
  assign cyc0 = cyc && (dsel == 0);
  assign stb0 = stb && (dsel == 0);
  assign cyc3 = cyc && (dsel == 1);
  assign stb3 = stb && (dsel == 1);

  logic              ack0, err0, rdy0, ack3, err3, rdy3;
  logic [31:0]       dat0, dat3;
  logic [NRW*32-1:0] regs0, regs3;
  logic [NRW-1:0]    pulse0, pulse3;

  wb_regbank_slave #(
    .DW(DW), .AW(AW), .NUM_RW(NRW), .NUM_RO(NRO), .WAIT_STATES(0), .BASE_ADDR(BASE)
  ) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_cyc_i(cyc0), .wbs_stb_i(stb0), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack0), .wbs_err_o(err0),
    .wbs_dat_o(dat0), .wbs_rdy_o(rdy0), .regs_o(regs0), .wr_pulse_o(pulse0), .status_i(status)
  );

  wb_regbank_slave #(
    .DW(DW), .AW(AW), .NUM_RW(NRW), .NUM_RO(NRO), .WAIT_STATES(3), .BASE_ADDR(BASE)
  ) u_dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .wbs_cyc_i(cyc3), .wbs_stb_i(stb3), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack3), .wbs_err_o(err3),
    .wbs_dat_o(dat3), .wbs_rdy_o(rdy3), .regs_o(regs3), .wr_pulse_o(pulse3), .status_i(status)
  );

  logic              ack, err, rdy;
  logic [31:0]       rdat;
  logic [NRW*32-1:0] regs;
  logic [NRW-1:0]    pulse;
  always_comb begin
    ack   = (dsel == 1) ? ack3 : ack0;
    err   = (dsel == 1) ? err3 : err0;
    rdy   = (dsel == 1) ? rdy3 : rdy0;
    rdat  = (dsel == 1) ? dat3 : dat0;
    regs  = (dsel == 1) ? regs3 : regs0;
    pulse = (dsel == 1) ? pulse3 : pulse0;
  end

  logic [31:0] m_regs [2][NRW];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model_vec(input int d);
    logic [255:0] v;
    v = '0;
    for (int k = 0; k < NRW; k++) v[k*32 +: 32] = m_regs[d][k];
    return v;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) for (int k = 0; k < NRW; k++) m_regs[d][k] = '0;
  endtask

  // One full transaction on the selected instance, checked against the model.
  task automatic xfer(input bit w, input logic [15:0] a, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd);
    int ws, ai, idx, lat;
    bit is_rw, is_ro, exp_ack;
    logic [31:0] exp_dat, v;
    logic [NRW-1:0] exp_pulse;
    ws  = (dsel == 1) ? 3 : 0;
    ai  = int'(a);
    idx = (ai < int'(BASE)) ? -1 : (ai - int'(BASE)) / 4;
    is_rw = (idx >= 0) && (idx < NRW);
    is_ro = (idx >= NRW) && (idx < NRW + NRO);
    exp_ack = is_rw || (is_ro && !w);
    exp_pulse = '0;
    exp_dat = '0;
    if (w && is_rw) begin
      v = m_regs[dsel][idx];
      for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
      m_regs[dsel][idx] = v;
      exp_pulse[idx] = 1'b1;
    end else if (!w && is_rw) begin
      exp_dat = m_regs[dsel][idx];
    end else if (!w && is_ro) begin
      exp_dat = status[(idx - NRW)*32 +: 32];
    end

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    lat = 0;
    while (!(ack || err) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    cyc = 1'b0; stb = 1'b0;
    rd = rdat;
    check_eq("latency", lat, ws);
    check_eq("ack", ack, exp_ack);
    check_eq("err", err, !exp_ack);
    check_eq("rdy_busy", rdy, 1'b0);
    check_eq("pulse", pulse, exp_pulse);
    check_eq("regs", regs, model_vec(dsel));
    if (!w) check_eq("rdata", rdat, exp_dat);
    @(posedge clk); #1;
    check_eq("resp_one_cycle", {ack, err}, 2'b00);
    check_eq("pulse_clear", pulse, '0);
    check_eq("rdy_idle", rdy, 1'b1);
  endtask

  logic [31:0] rd;

  initial begin
    model_clear();
    #1;
    check_eq("rst_out0", {ack0, err0, rdy0, dat0, pulse0}, {3'b001, 32'h0, 8'h0});
    check_eq("rst_out3", {ack3, err3, rdy3, dat3, pulse3}, {3'b001, 32'h0, 8'h0});
    check_eq("rst_regs", {regs0, regs3}, '0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait full write, then partial byte-lane write and readback.
    dsel = 0;
    xfer(1'b1, BASE + 16'd12, 4'hF, 32'hDEADBEEF, rd);
    check_eq("req034_reg3", regs0[3*32 +: 32], 32'hDEADBEEF);
    xfer(1'b1, BASE + 16'd12, 4'b0101, 32'h11223344, rd);
    check_eq("req035_reg3", regs0[3*32 +: 32], 32'hDE22BE44);
    xfer(1'b0, BASE + 16'd12, 4'hF, 32'h0, rd);
    check_eq("req035_read", rd, 32'hDE22BE44);

    // Three wait states, status word 1.
    dsel = 1;
    status = {32'h44440003, 32'h33330002, 32'hCAFE0001, 32'h11110000};
    xfer(1'b0, BASE + 16'((NRW + 1) * 4), 4'hF, 32'h0, rd);
    check_eq("req036_read", rd, 32'hCAFE0001);

    // Write to RO and read past the last status word.
    dsel = 0;
    xfer(1'b1, BASE + 16'(NRW * 4), 4'hF, 32'h12345678, rd);
    xfer(1'b0, BASE + 16'((NRW + NRO) * 4), 4'hF, 32'h0, rd);
    check_eq("req037_read", rd, 32'h0);

    for (int i = 0; i < 80; i++) begin
      int r;
      logic [15:0] a;
      dsel = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 15));
      if (r == 15) a = BASE - 16'(4 * $urandom_range(1, 8));
      else a = BASE + 16'(r * 4) + 16'($urandom_range(0, 3));
      status = {$urandom, $urandom, $urandom, $urandom};
      xfer(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom, rd);
    end

    // Abort by dropping cyc during the wait phase.
    dsel = 1;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 16'd20; sel = 4'hF; wdat = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check_eq("wait_rdy", rdy, 1'b0);
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_rdy", rdy, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check_eq("abort_noresp", {ack, err, pulse}, '0);
      @(posedge clk); #1;
    end
    check_eq("abort_regs", regs, model_vec(1));

    // Reset asserted mid-wait.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 16'd8; sel = 4'hF; wdat = 32'h5A5A5A5A;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_eq("midrst_out3", {ack3, err3, rdy3, dat3, pulse3}, {3'b001, 32'h0, 8'h0});
    check_eq("midrst_out0", {ack0, err0, rdy0, dat0, pulse0}, {3'b001, 32'h0, 8'h0});
    check_eq("midrst_regs", {regs0, regs3}, '0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check_eq("postrst_noresp", {ack3, err3, pulse3}, '0);
    end
    check_eq("postrst_regs", regs3, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regbank_slave.md
WB_REGBANK_SLAVE -- requirements
Module: wb_regbank_slave

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter AW, default 32, Wishbone address width.
REQ-003 SHALL have parameter NUM_RW, default 16, count of read/write control registers (1..64).
REQ-004 SHALL have parameter NUM_RO, default 4, count of read-only status registers (0..64).
REQ-005 SHALL have parameter WAIT_STATES, default 0, extra cycles inserted before ack (0..15).
REQ-006 SHALL have parameter BASE_ADDR, default 0, byte address of register 0, aligned to DW/8.
REQ-007 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port wb_rst_i, input, 1, reset, asynchronous, active-low.
REQ-009 SHALL have ports wbs_cyc_i, wbs_stb_i and wbs_we_i, each input, 1, Wishbone cycle, strobe and write-enable.
REQ-010 SHALL have ports wbs_sel_i (input, DW/8, byte lanes), wbs_adr_i (input, AW, byte address) and wbs_dat_i (input, DW, write data).
REQ-011 SHALL have ports wbs_ack_o (output, 1, normal termination), wbs_err_o (output, 1, error termination) and wbs_dat_o (output, DW, read data).
REQ-012 SHALL have port wbs_rdy_o, output, 1, high when the slave can accept a new request.
REQ-013 SHALL have ports regs_o (output, NUM_RW*DW, flattened control registers, register k at bits [k*DW +: DW]) and wr_pulse_o (output, NUM_RW, one-cycle write strobe per register).
REQ-014 SHALL have port status_i, input, NUM_RO*DW, flattened status words with the same packing.

Function
REQ-015 SHALL compute idx = (wbs_adr_i - BASE_ADDR) >> log2(DW/8); sub-word low address bits are ignored.
REQ-016 SHALL decode idx 0..NUM_RW-1 as RW register, NUM_RW..NUM_RW+NUM_RO-1 as RO status, else (including addresses below BASE_ADDR) as unmapped.
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP, with registered state.
REQ-018 IDLE: wbs_rdy_o=1; on cyc&stb, latch adr/we/sel/dat, go WAIT if WAIT_STATES>0, else RESP.
REQ-019 WAIT: count WAIT_STATES cycles, then RESP; wbs_rdy_o=0.
REQ-020 WAIT: if wbs_cyc_i drops, abort to IDLE; no write, no ack, no err.
REQ-021 RESP: exactly one cycle of wbs_ack_o (mapped) or wbs_err_o (unmapped, or write to RO); never both; then IDLE.
REQ-022 Latency: request sampled at edge N, response high in cycle N+1+WAIT_STATES; minimum request-to-request spacing 2+WAIT_STATES cycles.
REQ-023 Write commits on the edge entering RESP: only byte lanes with sel=1 change; regs_o shows the new value during the ack cycle.
REQ-024 wr_pulse_o[idx] SHALL be high during the ack cycle of every RW write, including sel=0; it is low otherwise.
REQ-025 Errored writes SHALL modify no register and raise no wr_pulse_o.
REQ-026 Reads: wbs_dat_o is registered, valid in the ack cycle and held until the next response; RW reads return the full register, RO reads return status_i sampled on the edge entering RESP.
REQ-027 Unmapped reads SHALL return 0 with wbs_err_o.
REQ-028 A request still present in RESP SHALL be ignored; the master must re-strobe after ack.

Reset
REQ-029 On wb_rst_i=0, asynchronously: state=IDLE, wait counter=0, all regs_o=0, wbs_dat_o=0, wbs_ack_o=0, wbs_err_o=0, wr_pulse_o=0.
REQ-030 wbs_rdy_o SHALL be 1 in reset.
REQ-031 Reset mid-transaction SHALL discard the transaction; no write, no response after release.

Structure
REQ-032 Package wb_regbank_pkg SHALL hold the FSM state enum, default parameter constants and the log2 byte-offset function.
REQ-033 Sub-module wb_regbank_decode (combinational idx/region decode) SHALL be the only child; the register array and byte-merge stay in the top.

Verification
REQ-034 Write 0xDEADBEEF to reg 3 with sel=1111 and WAIT_STATES=0 -> ack one cycle after the request, regs_o[3]=0xDEADBEEF, wr_pulse_o[3] high one cycle.
REQ-035 Reg 3=0xDEADBEEF, write 0x11223344 with sel=0101 -> reg 3=0xDE22BE44, then read returns 0xDE22BE44.
REQ-036 WAIT_STATES=3, read status word 1 (idx NUM_RW+1) with status_i word 1=0xCAFE0001 -> ack in cycle N+4, dat=0xCAFE0001.
REQ-037 Write to RO idx, and read idx NUM_RW+NUM_RO -> err one cycle, no ack, registers unchanged, read data 0.
REQ-038 WAIT_STATES=3, drop cyc in WAIT -> no ack/err, no write, rdy=1 next cycle; assert reset during WAIT -> all outputs at reset values.
